// File: rtl/window_buffer_3x3.sv
// ---------------------------------------------------------------------------
// window_buffer_3x3
//   3x3 sliding-window generator for a raster-order pixel stream. Two
//   IMG_W-deep line buffers supply the two previous rows. The upper buffer
//   can be loaded with an external feedback value instead of the row below
//   it, which turns the downstream filter into a recursive one.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   pixel beat qualifier (no backpressure)
//   in_sof     start of frame, forces the beat to position (0,0)
//   in_pixel   raster-order pixel
//   fb_en      select fb_data as the value pushed into the upper line buffer
//   fb_data    feedback value
//   win        9 taps, tap k=3r+c at win[DATA_W*k +: DATA_W], k=8 newest
//   out_valid  win is a complete window lying fully inside the image
//   out_row    centre row of win
//   out_col    centre column of win
//   frame_done one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module window_buffer_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_pixel,
    input  logic                       fb_en,
    input  logic [DATA_W-1:0]          fb_data,
    output logic [9*DATA_W-1:0]        win,
    output logic                       out_valid,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    // Position counters of the next beat to be accepted.
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    // Line-buffer write/read pointer. It is a pure IMG_W-beat delay and is
    // deliberately independent of the position counters, so in_sof does not
    // disturb it.
    logic [CW-1:0] ptr;

    logic [DATA_W-1:0] lb_lo [IMG_W];
    logic [DATA_W-1:0] lb_hi [IMG_W];
    logic [DATA_W-1:0] lo_out;
    logic [DATA_W-1:0] hi_out;

    // Window registers, w[r][c]: r=0 oldest row, c=0 oldest column.
    logic [DATA_W-1:0] w [3][3];

    // Position of the current beat after in_sof override.
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;
    logic          qual;
    logic          last_pix;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        cur_row  = in_sof ? '0 : row;
        cur_col  = in_sof ? '0 : col;
        qual     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    // Read-before-write: the popped value is the one stored IMG_W beats ago.
    assign lo_out = lb_lo[ptr];
    assign hi_out = lb_hi[ptr];

    // NOTE: line-buffer storage has no reset; stale contents are never
    // qualified because validity is gated by the position counters, and a
    // reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_lo[ptr] <= in_pixel;
            lb_hi[ptr] <= fb_en ? fb_data : lo_out;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row        <= '0;
            col        <= '0;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            // Position advance, raster order with wrap at frame end.
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end

            ptr <= (ptr == COL_LAST) ? '0 : ptr + 1'b1;

            // Shift window one column left, new right column from the
            // stream and the two line-buffer outputs.
            for (int r = 0; r < 3; r++) begin
                w[r][0] <= w[r][1];
                w[r][1] <= w[r][2];
            end
            w[0][2] <= hi_out;
            w[1][2] <= lo_out;
            w[2][2] <= in_pixel;

            out_valid  <= qual;
            frame_done <= last_pix;
            if (qual) begin
                out_row <= cur_row - 1'b1;
                out_col <= cur_col - 1'b1;
            end
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win[DATA_W*(3*r+c) +: DATA_W] = w[r][c];
        end
    end

endmodule
